// File: rtl/ps2_packet_rx.sv
// PS/2 host receive front end: deserialises device frames and assembles
// 3-byte mouse packets, all on the falling edge of the device clock.
module ps2_packet_rx #(
  parameter bit          SYNC_CHECK = 1'b1,
  parameter int unsigned ERR_W      = 4
) (
  input  logic             MOUSE_CLOCK,
  input  logic             rst,
  input  logic             MOUSE_DATA,
  input  logic             stream_en,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  output logic [23:0]      packet,
  output logic             pkt_toggle,
  output logic [ERR_W-1:0] parity_err_cnt,
  output logic [ERR_W-1:0] frame_err_cnt,
  output logic [ERR_W-1:0] sync_err_cnt
);

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned IDX_W   = 2;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [IDX_W-1:0]   byte_idx;
  logic [BYTE_W-1:0]  shift;
  logic [BYTE_W-1:0]  b0;
  logic [BYTE_W-1:0]  b1;
  logic               par_ok;

  // Saturating increment; counters stick at all-ones.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == ERR_MAX) ? v : v + ERR_W'(1);
  endfunction

  // Frame FSM, frame evaluation and packet assembly on the host sampling edge.
  always_ff @(negedge MOUSE_CLOCK or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      byte_idx       <= '0;
      shift          <= '0;
      b0             <= '0;
      b1             <= '0;
      par_ok         <= 1'b0;
      byte_out       <= '0;
      byte_valid     <= 1'b0;
      packet         <= '0;
      pkt_toggle     <= 1'b0;
      parity_err_cnt <= '0;
      frame_err_cnt  <= '0;
      sync_err_cnt   <= '0;
    end else begin
      byte_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (stream_en && !MOUSE_DATA) begin
            state   <= DATA;
            bit_cnt <= '0;
          end else if (!stream_en) begin
            byte_idx <= '0;
          end
        end
        DATA: begin
          shift   <= {MOUSE_DATA, shift[BYTE_W-1:1]};
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(7)) state <= PARITY;
        end
        PARITY: begin
          par_ok <= ((^shift) ^ MOUSE_DATA) == 1'b1;
          state  <= STOP;
        end
        STOP: begin
          state <= IDLE;
          if (!par_ok)     parity_err_cnt <= sat_inc(parity_err_cnt);
          if (!MOUSE_DATA) frame_err_cnt  <= sat_inc(frame_err_cnt);
          if (!par_ok || !MOUSE_DATA) begin
            // A bad frame drops the whole partial packet.
            byte_idx <= '0;
          end else begin
            byte_out   <= shift;
            byte_valid <= 1'b1;
            case (byte_idx)
              IDX_W'(0): begin
                if (SYNC_CHECK && !shift[3]) begin
                  sync_err_cnt <= sat_inc(sync_err_cnt);
                end else begin
                  b0       <= shift;
                  byte_idx <= IDX_W'(1);
                end
              end
              IDX_W'(1): begin
                b1       <= shift;
                byte_idx <= IDX_W'(2);
              end
              IDX_W'(2): begin
                packet     <= {b0, b1, shift};
                pkt_toggle <= ~pkt_toggle;
                byte_idx   <= '0;
              end
              default: byte_idx <= '0;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ps2_packet_rx.md
Name: ps2_packet_rx

Overview:
- Host-side PS/2 receive front end, clocked directly by the device clock.
- Deserialises 11-bit device-to-host frames and checks parity and stop bit.
- Assembles 3-byte mouse movement packets, with packet-sync checking on byte 0 bit 3.
- Presents each completed 24-bit packet with a toggle flag, which the system-clock packet consumer synchronises.

Parameters:
- SYNC_CHECK, 1: when 1, a packet's first byte must have bit 3 = 1; otherwise that byte is discarded.
- ERR_W, 4: width of each saturating error counter.

Ports:
- MOUSE_CLOCK  input  1  PS/2 device clock; all registers update on its falling edge.
- rst  input  1  asynchronous reset, active-high.
- MOUSE_DATA  input  1  PS/2 data line, sampled on the MOUSE_CLOCK falling edge.
- stream_en  input  1  quasi-static level; when 0, new frames are ignored.
- byte_out  output  8  last accepted byte.
- byte_valid  output  1  high for the edge interval after a byte is accepted.
- packet  output  24  last complete packet {byte0, byte1, byte2}.
- pkt_toggle  output  1  inverts once per completed packet.
- parity_err_cnt  output  ERR_W  saturating count of parity failures.
- frame_err_cnt  output  ERR_W  saturating count of stop-bit failures.
- sync_err_cnt  output  ERR_W  saturating count of discarded first bytes.

Behaviour:
- Clocking and reset:
  - Clock is MOUSE_CLOCK; reset rst is asynchronous and active-high.
  - Active edge is the falling edge of MOUSE_CLOCK (PS/2 host sampling edge).
  - On rst: state = IDLE, bit_cnt = 0, byte_idx = 0, shift and staging registers = 0.
  - On rst, every output is 0: byte_out, byte_valid, packet, pkt_toggle and all counters.
- Frame FSM (one transition per falling edge):
  - IDLE: if stream_en = 1 and MOUSE_DATA = 0 (start bit), go to DATA with bit_cnt = 0. Otherwise stay in IDLE, and if stream_en = 0 also clear byte_idx to 0.
  - DATA: shift LSB-first, shift <= {MOUSE_DATA, shift[7:1]}, and increment bit_cnt. After the 8th bit (bit_cnt = 7), go to PARITY.
  - PARITY: par_ok <= (XOR of shift[7:0] and MOUSE_DATA) == 1 (odd parity). Go to STOP.
  - STOP: stop_ok = MOUSE_DATA. Always return to IDLE.
- Frame evaluation at STOP:
  - If par_ok and stop_ok, the byte is accepted.
  - If !par_ok, parity_err_cnt increments. If !stop_ok, frame_err_cnt increments. Both increment when both fail.
  - Any failure discards the byte and clears byte_idx to 0, so the partial packet is dropped.
- Byte acceptance:
  - byte_out <= shift and byte_valid <= 1 on the STOP edge.
  - byte_valid clears on the next falling edge. Because MOUSE_CLOCK stops when the bus is idle, byte_valid may stay high indefinitely; other clock domains must use pkt_toggle.
- Packet assembly:
  - byte_idx = 0: if SYNC_CHECK = 1 and shift[3] = 0, discard the byte, increment sync_err_cnt and keep byte_idx = 0. Otherwise stage it as b0 and set byte_idx = 1.
  - byte_idx = 1: stage the byte as b1 and set byte_idx = 2.
  - byte_idx = 2: packet <= {b0, b1, shift}, pkt_toggle inverts, byte_idx = 0.
  - packet changes only on the third byte and is never partially updated.
- stream_en deasserted mid-frame: the current frame completes and is evaluated normally; the next start bit is ignored.
- Counters saturate at 2^ERR_W − 1 and never wrap. They are cleared only by rst.
- Reset mid-frame: the partial frame and partial packet are lost. The next clean start bit begins a fresh frame at byte_idx = 0.

Test Plan:
- Reset, stream_en = 1, send 0x08, 0x05, 0xFB with correct odd parity and stop = 1 -> packet = 0x0805FB, pkt_toggle 0→1, byte_valid pulses 3 times, all counters = 0.
- Send 0x08, then 0x05 with the parity bit inverted, then 0x09, 0x01, 0x02 -> parity_err_cnt = 1, packet unchanged after the bad frame, then packet = 0x090102 and pkt_toggle inverts exactly once.
- SYNC_CHECK = 1: send 0x00, then 0x08, 0x10, 0x20 -> sync_err_cnt = 1, packet = 0x081020. With SYNC_CHECK = 0, the same stream gives packet = 0x000810.
- Frame with stop bit = 0 as byte 2 of a packet -> frame_err_cnt = 1, byte_idx reset. The next 3 good bytes 0x18, 0x7F, 0x80 -> packet = 0x187F80.
- stream_en = 0: send 3 valid frames -> no byte_valid, packet and pkt_toggle unchanged. Then 20 parity-error frames with stream_en = 1 -> parity_err_cnt = 15 (saturated, ERR_W = 4).
- Assert rst after 4 data bits of a frame -> all outputs 0 immediately, no clock edge needed. Then 0x08, 0x00, 0x00 -> packet = 0x080000, pkt_toggle = 1.
